// File: rtl/agat9_kbd_pkg.sv
// Shared constants and types for the Agat-9 keyboard sequencer.
package agat9_kbd_pkg;

   localparam int unsigned KEY_CODE_W = 7;
   localparam int unsigned NUM_ROWS   = 6;
   localparam int unsigned NUM_COLS   = 16;
   localparam int unsigned NUM_KEYS   = NUM_ROWS * NUM_COLS;
   localparam int unsigned DATA_BITS  = 7;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

endpackage

// File: rtl/agat9_code_fifo.sv
// Small key-code queue; DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module agat9_code_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 7
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // A push into a full queue is still taken when a pop frees the slot in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // Storage array; contents need no reset since occupancy gates every read.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/agat9_key_sequencer.sv
// Agat-9 keyboard: matrix scanner, per-key debounce, code queue and serial host transmitter.
module agat9_key_sequencer
   import agat9_kbd_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 64,
   parameter int unsigned DEBOUNCE_SCANS = 3,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic [2:0]  row_drive,
   input  logic [15:0] sense,
   input  logic        host_strobe,
   input  logic        reply,
   output logic        key_data,
   output logic        busy,
   output logic        overflow
);

   localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DEB_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);
   localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_SCANS);

   logic [DIV_W-1:0]      div_cnt;
   logic                  sample;
   logic [KEY_CODE_W-1:0] row_base;

   logic [DEB_W-1:0]      deb_cnt [NUM_KEYS];
   logic [NUM_KEYS-1:0]   deb_state;
   logic [DEB_W-1:0]      cnt_nxt [NUM_COLS];
   logic [NUM_COLS-1:0]   row_state_nxt;
   logic                  scan_push;
   logic [KEY_CODE_W-1:0] scan_code;

   logic                  code_push;
   logic                  fifo_pop;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [KEY_CODE_W-1:0] fifo_dout;

   logic [2:0]            strobe_sync;
   logic                  advance;

   tx_state_t             tx_state;
   tx_state_t             tx_state_nxt;
   logic [KEY_CODE_W-1:0] shift_q;
   logic [KEY_CODE_W-1:0] shift_d;
   logic [BIT_W-1:0]      bit_q;
   logic [BIT_W-1:0]      bit_d;

   assign sample    = (div_cnt == DIV_W'(SCAN_DIV - 1));
   assign row_base  = {row_drive, 4'b0000};
   assign code_push = sample && scan_push;
   assign advance   = strobe_sync[1] && !strobe_sync[2];

   // Row divider: hold each row for SCAN_DIV cycles, then step to the next row.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt   <= '0;
         row_drive <= '0;
      end else if (sample) begin
         div_cnt   <= '0;
         row_drive <= (row_drive == 3'(NUM_ROWS - 1)) ? '0 : row_drive + 3'd1;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Next debounce counters/states for the current row; only the lowest new press is accepted,
   // other new presses stay released so they qualify again on the next scan.
   always_comb begin
      scan_push = 1'b0;
      scan_code = '0;
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
         cnt_nxt[c]       = deb_cnt[row_base + KEY_CODE_W'(c)];
         row_state_nxt[c] = deb_state[row_base + KEY_CODE_W'(c)];
         if (!sense[c]) begin
            if (cnt_nxt[c] != DEB_MAX) cnt_nxt[c] = cnt_nxt[c] + DEB_W'(1);
         end else if (cnt_nxt[c] != '0) begin
            cnt_nxt[c] = cnt_nxt[c] - DEB_W'(1);
         end
         if (cnt_nxt[c] == '0) begin
            row_state_nxt[c] = 1'b0;
         end else if (cnt_nxt[c] == DEB_MAX && !row_state_nxt[c] && !scan_push) begin
            scan_push        = 1'b1;
            scan_code        = row_base + KEY_CODE_W'(c);
            row_state_nxt[c] = 1'b1;
         end
      end
   end

   // Commit debounce results for the sampled row.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned k = 0; k < NUM_KEYS; k++) deb_cnt[k] <= '0;
         deb_state <= '0;
      end else if (sample) begin
         for (int unsigned c = 0; c < NUM_COLS; c++) begin
            deb_cnt[row_base + KEY_CODE_W'(c)]   <= cnt_nxt[c];
            deb_state[row_base + KEY_CODE_W'(c)] <= row_state_nxt[c];
         end
      end
   end

   agat9_code_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (KEY_CODE_W)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (code_push),
      .pop     (fifo_pop),
      .din     (scan_code),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Sticky overflow: a code arrived with no room and no simultaneous pop.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                                overflow <= 1'b0;
      else if (code_push && fifo_full && !fifo_pop) overflow <= 1'b1;
   end

   // Two-flop synchronizer for the host clock plus one delay flop for edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) strobe_sync <= '0;
      else          strobe_sync <= {strobe_sync[1:0], host_strobe};
   end

   // Transmitter state register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_state <= IDLE;
         shift_q  <= '0;
         bit_q    <= '0;
      end else begin
         tx_state <= tx_state_nxt;
         shift_q  <= shift_d;
         bit_q    <= bit_d;
      end
   end

   // Transmitter next state and outputs: start bit 0, seven bits LSB first, stop bit 1.
   always_comb begin
      tx_state_nxt = tx_state;
      shift_d      = shift_q;
      bit_d        = bit_q;
      fifo_pop     = 1'b0;
      key_data     = 1'b1;
      busy         = 1'b1;
      case (tx_state)
         IDLE: begin
            busy = 1'b0;
            if (reply && !fifo_empty) begin
               fifo_pop     = 1'b1;
               shift_d      = fifo_dout;
               bit_d        = '0;
               tx_state_nxt = START;
            end
         end
         START: begin
            key_data = 1'b0;
            if (advance) tx_state_nxt = DATA;
         end
         DATA: begin
            key_data = shift_q[0];
            if (advance) begin
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  tx_state_nxt = STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + BIT_W'(1);
               end
            end
         end
         STOP: begin
            if (advance) tx_state_nxt = IDLE;
         end
         default: tx_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_agat9_key_sequencer.sv
// Directed scoreboard bench for agat9_key_sequencer.
`timescale 1ns/1ps
module tb_agat9_key_sequencer;
   import agat9_kbd_pkg::*;

   localparam int unsigned SCAN_DIV = 8;
   localparam int unsigned SCAN_CYC = SCAN_DIV * NUM_ROWS;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [2:0]  row_drive;
   logic [15:0] sense;
   logic        host_strobe;
   logic        reply;
   logic        key_data;
   logic        busy;
   logic        overflow;

   logic [NUM_KEYS-1:0] keys_down;
   logic [6:0]          exp_q [$];
   int                  compared   = 0;
   int                  mismatched = 0;

   agat9_key_sequencer #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (3),
      .FIFO_DEPTH     (4)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .row_drive   (row_drive),
      .sense       (sense),
      .host_strobe (host_strobe),
      .reply       (reply),
      .key_data    (key_data),
      .busy        (busy),
      .overflow    (overflow)
   );

   always #5 clock = ~clock;

   // Key matrix model: a held key pulls its sense line low while its row is driven.
   always_comb sense = ~keys_down[{row_drive, 4'b0000} +: 16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   // One host clock rising edge; returns three clocks later, when the advance has taken effect.
   task automatic strobe();
      host_strobe = 1'b0;
      cycles(3);
      host_strobe = 1'b1;
      cycles(3);
   endtask

   task automatic wait_busy(input int bound);
      int n = 0;
      while (busy !== 1'b1 && n < bound) begin
         @(negedge clock);
         n++;
      end
      check("busy_rise", {31'd0, busy}, 1);
   endtask

   task automatic idle_watch(input string tag, input int n);
      int seen = 0;
      repeat (n) begin
         @(negedge clock);
         if (busy !== 1'b0) seen++;
      end
      check(tag, seen, 0);
   endtask

   task automatic recv_frame(input bit drop_reply);
      logic [6:0] got;
      logic [6:0] exp;
      got = '0;
      wait_busy(8 * SCAN_CYC);
      check("start_bit", {31'd0, key_data}, 0);
      if (drop_reply) reply = 1'b0;
      for (int i = 0; i < 7; i++) begin
         strobe();
         got[i] = key_data;
         check("busy_data", {31'd0, busy}, 1);
      end
      strobe();
      check("stop_bit", {31'd0, key_data}, 1);
      check("busy_stop", {31'd0, busy}, 1);
      strobe();
      check("busy_after_stop", {31'd0, busy}, 0);
      check("sb_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) begin
         exp = exp_q.pop_front();
         check("frame_code", {25'd0, got}, {25'd0, exp});
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          keys5 [5];
      logic [6:0]  abort_code;
      keys5 = '{95, 0, 50, 66, 83};

      reset_n     = 1'b0;
      host_strobe = 1'b0;
      reply       = 1'b0;
      keys_down   = '0;
      cycles(4);
      check("rst_row_drive", {29'd0, row_drive}, 0);
      check("rst_key_data", {31'd0, key_data}, 1);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_overflow", {31'd0, overflow}, 0);
      reset_n = 1'b1;
      cycles(2);

      // Key 37 (row 2, sense bit 5) held for several scans
      reply = 1'b1;
      keys_down[37] = 1'b1;
      exp_q.push_back(7'd37);
      recv_frame(1'b0);
      keys_down[37] = 1'b0;
      cycles(4 * SCAN_CYC);

      // Bounce low/high/low/low on key 10: no push until the third consecutive low
      begin
         logic pat [4];
         int   seen = 0;
         pat = '{1'b1, 1'b0, 1'b1, 1'b1};
         for (int w = 0; w < 4; w++) begin
            keys_down[10] = pat[w];
            repeat (SCAN_CYC) begin
               @(negedge clock);
               if (busy !== 1'b0) seen++;
            end
         end
         check("bounce_no_push", seen, 0);
      end
      exp_q.push_back(7'd10);
      recv_frame(1'b0);
      keys_down[10] = 1'b0;
      cycles(4 * SCAN_CYC);

      // Five presses with reply low: four queued, fifth dropped
      reply = 1'b0;
      for (int i = 0; i < 5; i++) begin
         keys_down[keys5[i]] = 1'b1;
         cycles(4 * SCAN_CYC);
         keys_down[keys5[i]] = 1'b0;
         if (i < 4) exp_q.push_back(7'(keys5[i]));
         if (i == 3) check("no_overflow_at_4", {31'd0, overflow}, 0);
      end
      check("overflow_at_5", {31'd0, overflow}, 1);
      strobe();
      strobe();
      check("idle_adv_busy", {31'd0, busy}, 0);
      check("idle_adv_data", {31'd0, key_data}, 1);
      cycles(4 * SCAN_CYC);
      reply = 1'b1;
      for (int i = 0; i < 4; i++) recv_frame(1'b0);
      idle_watch("no_fifth_frame", 2 * SCAN_CYC);
      check("overflow_sticky", {31'd0, overflow}, 1);

      // Keys 3 and 9 in the same row together: 3 first, 9 on the next scan
      keys_down[3] = 1'b1;
      keys_down[9] = 1'b1;
      exp_q.push_back(7'd3);
      exp_q.push_back(7'd9);
      recv_frame(1'b0);
      recv_frame(1'b0);
      keys_down[3] = 1'b0;
      keys_down[9] = 1'b0;
      cycles(4 * SCAN_CYC);

      // Reply dropped after the start bit: frame completes, next code waits
      keys_down[60] = 1'b1;
      keys_down[61] = 1'b1;
      exp_q.push_back(7'd60);
      exp_q.push_back(7'd61);
      recv_frame(1'b1);
      idle_watch("reply_low_holds", 4 * SCAN_CYC);
      reply = 1'b1;
      recv_frame(1'b0);
      keys_down[60] = 1'b0;
      keys_down[61] = 1'b0;
      cycles(4 * SCAN_CYC);

      // Reset after the fourth data bit aborts the frame and drops the queue
      abort_code = 7'd70;
      keys_down[70] = 1'b1;
      keys_down[71] = 1'b1;
      wait_busy(8 * SCAN_CYC);
      check("abort_start_bit", {31'd0, key_data}, 0);
      for (int i = 0; i < 4; i++) begin
         strobe();
         check("abort_data_bit", {31'd0, key_data}, {31'd0, abort_code[i]});
      end
      reset_n = 1'b0;
      #1;
      check("abort_key_data", {31'd0, key_data}, 1);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_overflow", {31'd0, overflow}, 0);
      check("abort_row_drive", {29'd0, row_drive}, 0);
      keys_down = '0;
      cycles(3);
      reset_n = 1'b1;
      idle_watch("no_frame_after_reset", 6 * SCAN_CYC);
      check("post_reset_overflow", {31'd0, overflow}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
